// File: rtl/btn_pulse_gen_if.sv
// Button front-end signal bundle: raw button in, debounced level and edge pulses out.
// The master side drives the raw button; the slave side is the debouncer.
interface btn_pulse_gen_if;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// Synchronises and debounces a raw push button, emitting single-cycle press/release pulses.
// Optional auto-repeat of press_pulse while held is enabled by defining AUTOREPEAT_EN.
module btn_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic            clk,
    input  logic            reset,
    btn_pulse_gen_if.slave  bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    generate
        if (SYNC_STAGES < 2)     begin : g_bad_sync   $error("SYNC_STAGES must be >= 2");     end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb    $error("DEBOUNCE_CYCLES must be >= 2"); end
        if (REPEAT_DELAY < 2)    begin : g_bad_delay  $error("REPEAT_DELAY must be >= 2");    end
        if (REPEAT_PERIOD < 2)   begin : g_bad_period $error("REPEAT_PERIOD must be >= 2");   end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Outputs are registered alongside the state so level and pulse move on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press_d   = ((state_q == PRESS_WAIT) && btn_s && (cnt_q == CNT_LAST)) || repeat_hit;
        release_d = (state_q == RELEASE_WAIT) && !btn_s && (cnt_q == CNT_LAST);
        level_d   = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

`ifdef AUTOREPEAT_EN
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = $clog2(RMAX + 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [RCNT_W-1:0] rtarget;
    logic              rep_q, rep_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rcnt_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            rep_q  <= rep_d;
        end
    end

    // rep_q switches the target from the initial delay to the steady repeat period.
    always_comb begin
        rcnt_d     = rcnt_q;
        rep_d      = rep_q;
        repeat_hit = 1'b0;
        rtarget    = rep_q ? RCNT_W'(REPEAT_PERIOD - 1) : RCNT_W'(REPEAT_DELAY - 1);
        if ((state_q == PRESS_WAIT) && (state_d == HELD)) begin
            rcnt_d = '0;
            rep_d  = 1'b0;
        end else if (state_d == IDLE) begin
            rcnt_d = '0;
            rep_d  = 1'b0;
        end else if ((state_q == HELD) && btn_s) begin
            if (rcnt_q == rtarget) begin
                repeat_hit = 1'b1;
                rcnt_d     = '0;
                rep_d      = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RCNT_W'(1);
            end
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen: directed scenarios plus randomized button activity,
// compared cycle by cycle against a run-length debounce model.
module tb_btn_pulse_gen;

    localparam int SYNC = 2;
`ifdef AUTOREPEAT_EN
    localparam int RD = 8;
    localparam int RP = 4;
`endif

    typedef struct packed {
        logic [7:0] sync;
        bit         level;
        int         run;
        int         hold;
        bit         press;
        bit         rel;
    } model_t;

    logic   clk;
    logic   reset;
    int     compared;
    int     mismatched;
    model_t mA;
    model_t mB;

    btn_pulse_gen_if busA ();
    btn_pulse_gen_if busB ();

    btn_pulse_gen #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dutA (
        .clk  (clk),
        .reset(reset),
        .bus  (busA.slave)
    );

    btn_pulse_gen #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(2),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dutB (
        .clk  (clk),
        .reset(reset),
        .bus  (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The accepted level flips once the synchronised button has disagreed with it for
    // deb consecutive samples; any agreeing sample restarts the run.
    function automatic model_t modelStep(model_t m, bit raw, bit rstn, int deb);
        model_t n;
        bit     v;
        n       = m;
        n.press = 1'b0;
        n.rel   = 1'b0;
        if (!rstn) begin
            n.sync  = '0;
            n.level = 1'b0;
            n.run   = 0;
            n.hold  = 0;
            return n;
        end
        v = m.sync[SYNC-1];
        if (v != m.level) begin
            n.run = m.run + 1;
            if (n.run == deb) begin
                n.level = v;
                n.run   = 0;
                n.hold  = 0;
                if (v) n.press = 1'b1;
                else   n.rel   = 1'b1;
            end
        end else begin
`ifdef AUTOREPEAT_EN
            if (m.level && m.run == 0) begin
                n.hold = m.hold + 1;
                if (n.hold >= RD && ((n.hold - RD) % RP) == 0) n.press = 1'b1;
            end
`endif
            n.run = 0;
        end
        n.sync = {m.sync[6:0], raw};
        return n;
    endfunction

    task automatic tick(input bit rawA, input bit rawB, input bit rstn);
        busA.btn_raw = rawA;
        busB.btn_raw = rawB;
        reset        = rstn;
        @(posedge clk);
        mA = modelStep(mA, rawA, rstn, 4);
        mB = modelStep(mB, rawB, rstn, 2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            compared++;
            if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== 3'b000) begin
                mismatched++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %b%b%b required 000", i,
                         busA.btn_level, busA.press_pulse, busA.release_pulse);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            compared++;
            if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== 3'b000) begin
                mismatched++;
                $display("[TB] FAIL reset_idle cycle %0d: got %b%b%b required 000", i,
                         busA.btn_level, busA.press_pulse, busA.release_pulse);
            end
        end
    endtask

    task automatic test_clean_press();
        int firstEdge;
        int pressCount;
        firstEdge  = -1;
        pressCount = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(1'b1, 1'b0, 1'b1);
            compared++;
            if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== {mA.level, mA.press, mA.rel}) begin
                mismatched++;
                $display("[TB] FAIL clean_press edge %0d: got %b%b%b expected %b%b%b", e,
                         busA.btn_level, busA.press_pulse, busA.release_pulse, mA.level, mA.press, mA.rel);
            end
            if (busA.press_pulse === 1'b1) begin
                pressCount++;
                if (firstEdge < 0) firstEdge = e;
            end
        end
        compared++;
        if (firstEdge !== 6) begin
            mismatched++;
            $display("[TB] FAIL clean_press_edge: got %0d required 6", firstEdge);
        end
`ifndef AUTOREPEAT_EN
        compared++;
        if (pressCount !== 1) begin
            mismatched++;
            $display("[TB] FAIL clean_press_count: got %0d required 1", pressCount);
        end
`endif
        compared++;
        if (busA.btn_level !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL clean_press_level: got %b required 1", busA.btn_level);
        end
        for (int e = 1; e <= 10; e++) begin
            tick(1'b0, 1'b0, 1'b1);
            compared++;
            if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== {mA.level, mA.press, mA.rel}) begin
                mismatched++;
                $display("[TB] FAIL clean_release edge %0d: got %b%b%b expected %b%b%b", e,
                         busA.btn_level, busA.press_pulse, busA.release_pulse, mA.level, mA.press, mA.rel);
            end
        end
    endtask

    task automatic test_bounce();
        bit pattern [$];
        int badCycles;
        pattern   = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        badCycles = 0;
        foreach (pattern[i]) begin
            tick(pattern[i], 1'b0, 1'b1);
            compared++;
            if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== {mA.level, mA.press, mA.rel}) begin
                mismatched++;
                $display("[TB] FAIL bounce_model cycle %0d: got %b%b%b expected %b%b%b", i,
                         busA.btn_level, busA.press_pulse, busA.release_pulse, mA.level, mA.press, mA.rel);
            end
            if (busA.press_pulse !== 1'b0 || busA.btn_level !== 1'b0) badCycles++;
        end
        compared++;
        if (badCycles !== 0) begin
            mismatched++;
            $display("[TB] FAIL bounce_reject: got %0d active cycles required 0", badCycles);
        end
    endtask

    task automatic test_release_bounce();
        bit pattern [$];
        int relEdge;
        int relCount;
        int pressCount;
        relEdge    = -1;
        relCount   = 0;
        pressCount = 0;
        for (int e = 1; e <= 10; e++) tick(1'b1, 1'b0, 1'b1);
        compared++;
        if (busA.btn_level !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_setup_level: got %b required 1", busA.btn_level);
        end
        pattern = '{0, 0, 1};
        foreach (pattern[i]) begin
            tick(pattern[i], 1'b0, 1'b1);
            if (busA.press_pulse === 1'b1) pressCount++;
            if (busA.release_pulse === 1'b1) relCount++;
        end
        for (int k = 0; k <= 12; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            compared++;
            if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== {mA.level, mA.press, mA.rel}) begin
                mismatched++;
                $display("[TB] FAIL release_model k+%0d: got %b%b%b expected %b%b%b", k,
                         busA.btn_level, busA.press_pulse, busA.release_pulse, mA.level, mA.press, mA.rel);
            end
            if (busA.press_pulse === 1'b1) pressCount++;
            if (busA.release_pulse === 1'b1) begin
                relCount++;
                if (relEdge < 0) relEdge = k;
            end
        end
        compared++;
        if (relEdge !== 5 || relCount !== 1) begin
            mismatched++;
            $display("[TB] FAIL release_edge: got k+%0d (count %0d) required k+5 (count 1)", relEdge, relCount);
        end
        compared++;
        if (pressCount !== 0 || busA.btn_level !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL release_after: got presses %0d level %b required 0 and 0", pressCount, busA.btn_level);
        end
    endtask

    task automatic test_reset_mid();
        int pressBefore;
        int firstEdge;
        pressBefore = 0;
        firstEdge   = -1;
        for (int e = 1; e <= 4; e++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (busA.press_pulse === 1'b1) pressBefore++;
        end
        tick(1'b1, 1'b0, 1'b0);
        compared++;
        if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== 3'b000 || pressBefore !== 0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_abort: got %b%b%b presses %0d required 000 presses 0",
                     busA.btn_level, busA.press_pulse, busA.release_pulse, pressBefore);
        end
        for (int e = 1; e <= 12; e++) begin
            tick(1'b1, 1'b0, 1'b1);
            compared++;
            if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== {mA.level, mA.press, mA.rel}) begin
                mismatched++;
                $display("[TB] FAIL reset_mid_model edge %0d: got %b%b%b expected %b%b%b", e,
                         busA.btn_level, busA.press_pulse, busA.release_pulse, mA.level, mA.press, mA.rel);
            end
            if (busA.press_pulse === 1'b1 && firstEdge < 0) firstEdge = e;
        end
        compared++;
        if (firstEdge !== 6) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_press_edge: got %0d required 6", firstEdge);
        end
        for (int e = 1; e <= 10; e++) tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_autorepeat();
        int got [$];
        int want [$];
`ifdef AUTOREPEAT_EN
        want = '{6, 14, 18, 22, 26, 30};
`else
        want = '{6};
`endif
        for (int e = 1; e <= 30; e++) begin
            tick(1'b1, 1'b0, 1'b1);
            compared++;
            if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== {mA.level, mA.press, mA.rel}) begin
                mismatched++;
                $display("[TB] FAIL repeat_model edge %0d: got %b%b%b expected %b%b%b", e,
                         busA.btn_level, busA.press_pulse, busA.release_pulse, mA.level, mA.press, mA.rel);
            end
            if (busA.press_pulse === 1'b1) got.push_back(e);
        end
        compared++;
        if (got.size() !== want.size()) begin
            mismatched++;
            $display("[TB] FAIL repeat_count: got %0d pulses required %0d", got.size(), want.size());
        end else begin
            foreach (want[i]) begin
                compared++;
                if (got[i] !== want[i]) begin
                    mismatched++;
                    $display("[TB] FAIL repeat_edge[%0d]: got %0d required %0d", i, got[i], want[i]);
                end
            end
        end
        for (int e = 1; e <= 10; e++) tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_min_debounce();
        int glitchPress;
        int firstEdge;
        glitchPress = 0;
        firstEdge   = -1;
        tick(1'b0, 1'b1, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (busB.press_pulse === 1'b1 || busB.btn_level === 1'b1) glitchPress++;
        end
        compared++;
        if (glitchPress !== 0) begin
            mismatched++;
            $display("[TB] FAIL min_glitch_reject: got %0d active cycles required 0", glitchPress);
        end
        for (int e = 1; e <= 10; e++) begin
            tick(1'b0, (e <= 2), 1'b1);
            compared++;
            if ({busB.btn_level, busB.press_pulse, busB.release_pulse} !== {mB.level, mB.press, mB.rel}) begin
                mismatched++;
                $display("[TB] FAIL min_model edge %0d: got %b%b%b expected %b%b%b", e,
                         busB.btn_level, busB.press_pulse, busB.release_pulse, mB.level, mB.press, mB.rel);
            end
            if (busB.press_pulse === 1'b1 && firstEdge < 0) firstEdge = e;
        end
        compared++;
        if (firstEdge !== 4) begin
            mismatched++;
            $display("[TB] FAIL min_press_edge: got %0d required 4", firstEdge);
        end
    endtask

    task automatic test_random();
        bit rA, rB, rst;
        int lenA, lenB;
        rA = 0; rB = 0; lenA = 0; lenB = 0;
        for (int c = 0; c < 600; c++) begin
            if (lenA == 0) begin rA = 1'($urandom_range(0, 1)); lenA = $urandom_range(1, 7); end
            if (lenB == 0) begin rB = 1'($urandom_range(0, 1)); lenB = $urandom_range(1, 4); end
            lenA--;
            lenB--;
            rst = ($urandom_range(0, 59) != 0);
            tick(rA, rB, rst);
            compared++;
            if ({busA.btn_level, busA.press_pulse, busA.release_pulse} !== {mA.level, mA.press, mA.rel}) begin
                mismatched++;
                $display("[TB] FAIL random_a cycle %0d: got %b%b%b expected %b%b%b", c,
                         busA.btn_level, busA.press_pulse, busA.release_pulse, mA.level, mA.press, mA.rel);
            end
            compared++;
            if ({busB.btn_level, busB.press_pulse, busB.release_pulse} !== {mB.level, mB.press, mB.rel}) begin
                mismatched++;
                $display("[TB] FAIL random_b cycle %0d: got %b%b%b expected %b%b%b", c,
                         busB.btn_level, busB.press_pulse, busB.release_pulse, mB.level, mB.press, mB.rel);
            end
            compared++;
            if (busA.press_pulse === 1'b1 && busA.release_pulse === 1'b1) begin
                mismatched++;
                $display("[TB] FAIL random_exclusive cycle %0d: got both pulses high required at most one", c);
            end
        end
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        mA           = '0;
        mB           = '0;
        reset        = 1'b0;
        busA.btn_raw = 1'b0;
        busB.btn_raw = 1'b0;
        @(negedge clk);
        $display("[TB] starting btn_pulse_gen bench");
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_reset_mid();
        test_autorepeat();
        test_min_debounce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
